// File: rtl/alu_flag_buffer.sv
// Captures ALU results under valid/ready, derives {C,N,Z} flags into a 2-entry FIFO
// and holds the architectural carry register that feeds the ALU carry-in.
module alu_flag_buffer #(
  parameter int data_size    = 8,
  parameter int op_code_size = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [op_code_size-1:0] op_code_in,
  input  logic [data_size-1:0]    result_in,
  input  logic                    co_in,
  input  logic                    carry_clr,
  output logic                    carry_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [data_size-1:0]    result_out,
  output logic [2:0]              flags_out
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 carry_q, carry_d;
  logic [data_size-1:0] mem_res_q [2];
  logic [data_size-1:0] mem_res_d [2];
  logic [2:0]           mem_flg_q [2];
  logic [2:0]           mem_flg_d [2];
  logic [data_size-1:0] head_res_q, head_res_d;
  logic [2:0]           head_flg_q, head_flg_d;
  logic                 push, pop;
  logic [2:0]           new_flags;

  // Arithmetic ops (0001..0110) latch carry-out, 0111 clears, pass and logical ops keep it.
  function automatic logic carry_update(input logic [op_code_size-1:0] op,
                                        input logic co, input logic c);
    if (op[op_code_size-1]) return c;
    case (op[2:0])
      3'd0:    return c;
      3'd7:    return 1'b0;
      default: return co;
    endcase
  endfunction

  assign in_ready   = (count_q != FULL);
  assign out_valid  = (count_q != EMPTY);
  assign carry_out  = carry_q;
  assign result_out = head_res_q;
  assign flags_out  = head_flg_q;

  always_comb begin
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;

    carry_d = carry_q;
    if (carry_clr)
      carry_d = 1'b0;
    else if (push)
      carry_d = carry_update(op_code_in, co_in, carry_q);

    new_flags = {carry_d, result_in[data_size-1], (result_in == '0)};

    mem_res_d = mem_res_q;
    mem_flg_d = mem_flg_q;
    wr_ptr_d  = wr_ptr_q;
    if (push) begin
      mem_res_d[wr_ptr_q] = result_in;
      mem_flg_d[wr_ptr_q] = new_flags;
      wr_ptr_d            = ~wr_ptr_q;
    end
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Output registers mirror the next head; they freeze once the FIFO drains.
    head_res_d = head_res_q;
    head_flg_d = head_flg_q;
    if (count_d != EMPTY) begin
      head_res_d = mem_res_d[rd_ptr_d];
      head_flg_d = mem_flg_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= EMPTY;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      carry_q    <= 1'b0;
      head_res_q <= '0;
      head_flg_q <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_res_q[i] <= '0;
        mem_flg_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      carry_q    <= carry_d;
      head_res_q <= head_res_d;
      head_flg_q <= head_flg_d;
      mem_res_q  <= mem_res_d;
      mem_flg_q  <= mem_flg_d;
    end
  end

endmodule

// File: doc/alu_flag_buffer.md
Name: alu_flag_buffer

Overview:
- Downstream stage of the combinational 8-bit ALU. Captures each ALU result and carry-out under a valid/ready handshake.
- Derives carry, negative and zero flags and holds results in a 2-entry output FIFO.
- Keeps the architectural carry register. That register drives the ALU carry-in for chained ADC/SBB sequences.

Parameters:
- data_size, 8, width of ALU result / data path.
- op_code_size, 4, width of ALU op code (encoding fixed as below; value other than 4 not supported).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU output (result_in/co_in/op_code_in) valid this cycle.
- in_ready  output  1  buffer can accept an entry this cycle.
- op_code_in  input  op_code_size  op code that produced result_in.
- result_in  input  data_size  ALU result.
- co_in  input  1  ALU carry/borrow out.
- carry_clr  input  1  synchronous clear of carry register.
- carry_out  output  1  current carry register; wired to ALU cin_in.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- result_out  output  data_size  head entry result.
- flags_out  output  3  head entry flags {C,N,Z}.

Behaviour:
- Reset: rst_n low asynchronously clears the following; takes effect immediately, including mid-transfer, and in-flight entries are discarded:
  - FIFO count, read and write pointers;
  - carry register;
  - all storage.
- Values under reset: out_valid=0, result_out=0, flags_out=0, carry_out=0, in_ready=1.
- Accept: push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count < 2). It depends only on registered count, never combinationally on out_ready.
  - When full, a same-cycle pop does not enable a push; in_ready reasserts the cycle after the pop.
- in_valid while in_ready=0 is ignored; the upstream holds data.
- Latency: entry pushed in cycle N is visible at the outputs (out_valid=1) in cycle N+1 when the FIFO was empty. Otherwise it follows older entries in order.
- Outputs result_out/flags_out are registered storage of the head entry. When out_valid=0 they hold the last value (0 after reset).
- Count updates:
  - push only: +1;
  - pop only: -1;
  - push and pop with count=1: count stays 1, new entry becomes head next cycle;
  - push and pop with count=0: impossible (out_valid=0).
- Pointers are 1-bit and wrap 1->0.
- Carry register update on push, by op_code_in:
  - 0001..0110 (add, adc, sub, sbb, inc, dec): C <= co_in.
  - 0111: C <= 0.
  - 0000 (pass) and 1xxx (logical): C unchanged.
- carry_clr=1 forces C <= 0 and has priority over a coincident push update. A coincident push is still accepted and its stored flags use C=0.
- Stored flags per entry:
  - C = carry register value after this push's update;
  - N = result_in[data_size-1];
  - Z = (result_in == 0).
- carry_out reflects the register, so a chained op sees the updated carry starting the cycle after the producing push.
- No other states. Control is count-based: EMPTY(0), ONE(1), FULL(2).

Test Plan:
- Reset: assert rst_n=0 mid-stream with count=2 -> out_valid=0, in_ready=1, carry_out=0 immediately.
- Single push: op 0001, result_in=8'h00, co_in=1, out_ready=0 -> next cycle out_valid=1, result_out=8'h00, flags_out=3'b101, carry_out=1.
- Fill/backpressure: push 8'h80 (op 1000) then 8'h05 (op 0000), out_ready=0 -> in_ready=0 after second push.
  - flags of first = {C_prev,1,0}.
  - Third in_valid ignored.
  - Pop with out_ready=1 -> in_ready=1 the following cycle, order preserved.
- Simultaneous push/pop at count=1: stream 4 entries with out_ready=1 continuously -> one output per cycle, count stays 1, no loss or duplication.
- Carry rules and priority:
  - op 0011 with co_in=1 -> C=1.
  - op 1010 -> C stays 1.
  - op 0111 -> C=0.
  - op 0010 with co_in=1 and carry_clr=1 -> C=0, and that entry's flags C=0.
